char_sequencer: RTL

- Upstream feeder for the segment animator: buffers characters written from the input pins into a small FIFO.
- Releases one character at a time, paced by the 60 Hz tick from the clock divider.
- Drives the animator's character bus plus a one-cycle strobe, so characters are shown for a fixed time with a blank gap between them.
- Sits between the top-level ui_in pins and the animator's charInput/charAvailable.

---
 rtl/char_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/char_sequencer.sv
// rtl/char_sequencer.sv - character FIFO with tick-paced release to the segment animator
// Buffers pin-written characters and strobes them out, each held then followed by a blank.
module char_sequencer #(
  parameter int DEPTH       = 8,
  parameter int HOLD_TICKS  = 30,
  parameter int BLANK_TICKS = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tick_in,
  input  logic                       wr_req,
  input  logic [6:0]                 wr_data,
  input  logic                       clear,
  output logic [6:0]                 char_out,
  output logic                       char_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       busy
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int MAXT = (HOLD_TICKS > BLANK_TICKS) ? HOLD_TICKS : BLANK_TICKS;
  localparam int TW   = $clog2(MAXT) + 1;

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t          state;
  logic [6:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_nxt;
  logic [TW-1:0]   tick_cnt;
  logic            s1, s2, s3;
  logic            rise, push, pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= wr_req;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  // full/empty are registered, so both decisions use the pre-update occupancy
  assign push = rise & ~full & ~clear;
  assign pop  = (state == IDLE) & ~empty & ~clear;
  assign busy = (state != IDLE);

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + 1'b1;
    else if (!push && pop)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      overflow   <= 1'b0;
      char_out   <= '0;
      char_valid <= 1'b0;
      tick_cnt   <= '0;
    end else begin
      char_valid <= 1'b0;
      if (clear) begin
        state    <= IDLE;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        full     <= 1'b0;
        empty    <= 1'b1;
        overflow <= 1'b0;
        char_out <= '0;
        tick_cnt <= '0;
      end else begin
        if (rise && full)
          overflow <= 1'b1;
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        count <= count_nxt;
        full  <= (count_nxt == CW'(DEPTH));
        empty <= (count_nxt == '0);

        case (state)
          IDLE: begin
            if (pop) begin
              char_out   <= mem[rd_ptr];
              char_valid <= 1'b1;
              tick_cnt   <= '0;
              state      <= SHOW;
            end
          end
          SHOW: begin
            if (tick_in) begin
              if (tick_cnt == TW'(HOLD_TICKS - 1)) begin
                tick_cnt <= '0;
                if (BLANK_TICKS > 0) begin
                  char_out   <= '0;
                  char_valid <= 1'b1;
                  state      <= GAP;
                end else begin
                  state <= IDLE;
                end
              end else begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
          end
          GAP: begin
            if (tick_in) begin
              if (tick_cnt == TW'(BLANK_TICKS - 1)) begin
                tick_cnt <= '0;
                state    <= IDLE;
              end else begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
